// File: rtl/screen_msg_sequencer_if.sv
// Byte handshake between the message sequencer and the UART transmitter.
interface screen_msg_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/screen_msg_sequencer.sv
// Serial-LCD message sequencer: after a power-up wait, and again whenever the
// scale selection changes, streams "clear screen" + "SCALE:n" to the UART TX
// one byte at a time over a valid/ready handshake.
// Optional build macro SCREEN_REFRESH_EN: periodic forced re-send from IDLE.
module screen_msg_sequencer #(
  parameter int unsigned BOOT_CYCLES    = 5000000,
  parameter logic [7:0]  CMD_PREFIX     = 8'hFE,
  parameter logic [7:0]  CMD_CLEAR      = 8'h01,
  parameter int unsigned REFRESH_CYCLES = 50000000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [2:0]                    scale,
  screen_msg_sequencer_if.master        tx,
  output logic                          busy
);

  typedef enum logic [1:0] {
    BOOT,
    LOAD,
    SEND,
    IDLE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd8;

  state_t      state, state_next;
  logic [31:0] boot_cnt, boot_cnt_next;
  logic [3:0]  idx, idx_next;
  logic [2:0]  snap, snap_next;
  logic [7:0]  data_next;
  logic        valid_next;
  logic        busy_next;
  logic        xfer;

`ifdef SCREEN_REFRESH_EN
  logic [31:0] refresh_cnt, refresh_cnt_next;
`else
  logic unused_refresh;
  assign unused_refresh = ^REFRESH_CYCLES;
`endif

  assign xfer = tx.tx_valid && tx.tx_ready;

  function automatic logic [7:0] msg_byte(input logic [3:0] i, input logic [2:0] s);
    case (i)
      4'd0:    msg_byte = CMD_PREFIX;
      4'd1:    msg_byte = CMD_CLEAR;
      4'd2:    msg_byte = 8'h53;
      4'd3:    msg_byte = 8'h43;
      4'd4:    msg_byte = 8'h41;
      4'd5:    msg_byte = 8'h4C;
      4'd6:    msg_byte = 8'h45;
      4'd7:    msg_byte = 8'h3A;
      4'd8:    msg_byte = 8'h30 + {5'd0, s};
      default: msg_byte = 8'h00;
    endcase
  endfunction

  // State and registered outputs/datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      idx         <= '0;
      snap        <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b1;
`ifdef SCREEN_REFRESH_EN
      refresh_cnt <= '0;
`endif
    end else begin
      state       <= state_next;
      boot_cnt    <= boot_cnt_next;
      idx         <= idx_next;
      snap        <= snap_next;
      tx.tx_data  <= data_next;
      tx.tx_valid <= valid_next;
      busy        <= busy_next;
`ifdef SCREEN_REFRESH_EN
      refresh_cnt <= refresh_cnt_next;
`endif
    end
  end

  // Next-state decision
  always_comb begin
    state_next = state;
    case (state)
      BOOT: if (boot_cnt == BOOT_CYCLES - 1) state_next = LOAD;
      LOAD: state_next = SEND;
      SEND: if (xfer && (idx == LAST_IDX)) state_next = IDLE;
      IDLE: begin
        if (scale != snap) state_next = LOAD;
`ifdef SCREEN_REFRESH_EN
        else if (refresh_cnt == REFRESH_CYCLES - 1) state_next = LOAD;
`endif
      end
      default: state_next = BOOT;
    endcase
  end

  // Next values of the output registers and datapath; busy is registered
  // from the next state so it equals "state is not IDLE" without a comb path
  always_comb begin
    boot_cnt_next = boot_cnt;
    idx_next      = idx;
    snap_next     = snap;
    data_next     = tx.tx_data;
    valid_next    = tx.tx_valid;
    busy_next     = (state_next != IDLE);
`ifdef SCREEN_REFRESH_EN
    refresh_cnt_next = ((state == IDLE) && (state_next == IDLE)) ? refresh_cnt + 32'd1 : '0;
`endif
    case (state)
      BOOT: begin
        if (boot_cnt == BOOT_CYCLES - 1) boot_cnt_next = '0;
        else                             boot_cnt_next = boot_cnt + 32'd1;
      end
      LOAD: begin
        snap_next  = scale;
        idx_next   = '0;
        data_next  = msg_byte(4'd0, scale);
        valid_next = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            valid_next = 1'b0;
          end else begin
            idx_next  = idx + 4'd1;
            data_next = msg_byte(idx + 4'd1, snap);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_screen_msg_sequencer.sv
// Self-checking bench for screen_msg_sequencer with BOOT_CYCLES=16.
// Build with SCREEN_REFRESH_EN defined to run the periodic-refresh scenario.
module tb_screen_msg_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] scale = 3'd0;
  logic       busy;

  screen_msg_sequencer_if bus();

  screen_msg_sequencer #(
    .BOOT_CYCLES(16),
    .REFRESH_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .scale(scale),
    .tx(bus.master),
    .busy(busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int xfers  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Expected message content for a given scale digit
  function automatic void push_msg(input logic [2:0] s);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h30 + {5'd0, s});
  endfunction

  // Compare process: every transferred byte against the expected stream,
  // and hold-stability whenever the previous cycle was stalled
  initial begin : compare
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (prev_stall) begin
          check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
          check("hold_data", {24'd0, bus.tx_data}, {24'd0, prev_data});
        end
        if (bus.tx_valid && bus.tx_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_byte: got %0h required no transfer", bus.tx_data);
          end else begin
            check("byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
          end
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_remaining(input int left);
    int n = 0;
    while (exp_q.size() > left && n < 200) begin
      tick();
      n++;
    end
    check("reach_index", {31'd0, exp_q.size() <= left}, 32'd1);
  endtask

  // Measures a contiguous valid run (tx_ready=1); ends on the first tick after it
  task automatic msg_run(input string name);
    int r = 1;
    while (bus.tx_valid && r < 20) begin
      tick();
      if (bus.tx_valid) r++;
    end
    check(name, r, 9);
    check("busy_after_msg", {31'd0, busy}, 32'd0);
  endtask

  // Releases reset; first valid must be visible after edge 17
  task automatic boot_seq();
    int first = 0;
    int bad = 0;
    int e = 0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    while (first == 0 && e < 40) begin
      e++;
      tick();
      if (bus.tx_valid) first = e;
      else if (busy !== 1'b1) bad++;
    end
    check("boot_busy_drop", bad, 0);
    check("first_valid_edge", first, 17);
    check("first_byte", {24'd0, bus.tx_data}, 32'hFE);
    msg_run("valid_run_len");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int x0;
    int g;
    bus.tx_ready = 1'b1;
    reset_n = 1'b0;
`ifdef SCREEN_REFRESH_EN
    scale = 3'd1;
`else
    scale = 3'd3;
`endif
    repeat (3) tick();
    check("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

`ifdef SCREEN_REFRESH_EN
    push_msg(3'd1);
    boot_seq();
    // 100 IDLE cycles plus the LOAD cycle separate consecutive messages
    for (int k = 0; k < 3; k++) begin
      push_msg(3'd1);
      g = 0;
      while (!bus.tx_valid && g < 400) begin
        g++;
        tick();
      end
      check("refresh_gap", g, 101);
      msg_run("refresh_run_len");
    end
    check("refresh_drained", exp_q.size(), 0);
`else
    // Boot message, then silence
    push_msg(3'd3);
    boot_seq();
    x0 = xfers;
    repeat (1000) tick();
    check("boot_silence", xfers, x0);
    check("boot_drained", exp_q.size(), 0);

    // Change 3->5: LOAD on the next edge, valid after the one after
    scale = 3'd5;
    push_msg(3'd5);
    tick();
    check("chg_valid_n", {31'd0, bus.tx_valid}, 32'd0);
    check("chg_busy_n", {31'd0, busy}, 32'd1);
    tick();
    check("chg_valid_n1", {31'd0, bus.tx_valid}, 32'd1);
    check("chg_data_n1", {24'd0, bus.tx_data}, 32'hFE);
    wait_drain("chg_drain", 50);
    check("chg_busy_idle", {31'd0, busy}, 32'd0);

    // Rewriting the same value causes no traffic
    scale = 3'd5;
    x0 = xfers;
    repeat (50) tick();
    check("same_silence", xfers, x0);

    // Backpressure with pseudo-random tx_ready
    scale = 3'd0;
    push_msg(3'd0);
    x0 = xfers;
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      tick();
      bus.tx_ready = 1'($urandom_range(0, 1));
    end
    bus.tx_ready = 1'b1;
    check("bp_drain", exp_q.size(), 0);
    check("bp_count", xfers - x0, 9);
    repeat (5) tick();
    check("bp_busy_idle", {31'd0, busy}, 32'd0);

    // Mid-message change 2->6 at index 4: old message completes, new one follows
    scale = 3'd2;
    push_msg(3'd2);
    wait_remaining(5);
    check("mid_idx4_data", {24'd0, bus.tx_data}, 32'h41);
    scale = 3'd6;
    push_msg(3'd6);
    wait_drain("mid_drain", 100);
    repeat (3) tick();
    check("mid_busy_idle", {31'd0, busy}, 32'd0);

    // 6->2, then 2->6->2 inside that message: only one message
    scale = 3'd2;
    push_msg(3'd2);
    wait_remaining(5);
    scale = 3'd6;
    tick();
    tick();
    scale = 3'd2;
    wait_drain("revert_drain", 50);
    x0 = xfers;
    repeat (50) tick();
    check("revert_silence", xfers, x0);

    // Reset at index 5: valid drops at once, full restart from BOOT
    scale = 3'd7;
    push_msg(3'd7);
    wait_remaining(4);
    check("rst_mid_idx5_data", {24'd0, bus.tx_data}, 32'h4C);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    check("rst_mid_data", {24'd0, bus.tx_data}, 32'd0);
    exp_q.delete();
    push_msg(3'd7);
    repeat (3) tick();
    boot_seq();
    check("rst_drained", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
